// File: rtl/rr_sample_arb_pkg.sv
// Package for the round-robin sampling arbiter: state encoding and reset constants.
package rr_sample_arb_pkg;

    // Arbiter states: no grant outstanding, or a grant with its beat counter running.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // dataout is the inverted capture flop, so the flop resets to the complement.
    localparam logic DATAOUT_RST = 1'b1;
    localparam logic CAP_RST     = ~DATAOUT_RST;

    // Owner resets to the highest index so the first rotation lands on requester 0.
    function automatic int owner_rst_idx(input int n_req);
        return n_req - 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: the first requester strictly after
// the last owner (wrapping), which may be the last owner itself if it is the
// only one requesting.
module rr_pick
    import rr_sample_arb_pkg::*;
#(
    parameter int   N_REQ = 4,
    localparam int  IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] owner_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic             found_s;
    logic [IDX_W-1:0] idx_s;
    logic [IDX_W-1:0] cand_s;

    // Scan the requesters in rotating order starting just after the last owner.
    always_comb begin
        found_s = 1'b0;
        idx_s   = {IDX_W{1'b0}};
        cand_s  = {IDX_W{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            cand_s = IDX_W'((int'(owner_i) + k) % N_REQ);
            if (!found_s && req_i[cand_s]) begin
                found_s = 1'b1;
                idx_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Expand the chosen index into a one-hot vector; empty when nobody requests.
    always_comb begin
        grant_o = {N_REQ{1'b0}};
        if (found_s) begin
            grant_o[idx_s] = 1'b1;
        end else begin
            grant_o = {N_REQ{1'b0}};
        end
    end

    assign idx_o = idx_s;
    assign any_o = found_s;

endmodule

// File: rtl/rr_sample_arb.sv
// Round-robin arbiter sharing one capture flop + output inverter between
// N_REQ requesters, granting BURST beats per grant.
// Optional feature macro: RR_SAMPLE_ARB_LOCK_EN adds a per-requester lock
// input that extends the current grant by another burst.
module rr_sample_arb
    import rr_sample_arb_pkg::*;
#(
    parameter int  N_REQ = 4,
    parameter int  BURST = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] datain,
`ifdef RR_SAMPLE_ARB_LOCK_EN
    input  logic [N_REQ-1:0] lock,
`endif
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] owner,
    output logic             valid,
    output logic             dataout
);

    localparam int               CNT_W    = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);
    localparam logic [IDX_W-1:0] OWN_RST  = IDX_W'(owner_rst_idx(N_REQ));

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               cap_q,   cap_d;
    logic               valid_q, valid_d;

    logic [N_REQ-1:0]   pick_grant_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_any_s;
    logic [N_REQ-1:0]   lock_s;
    logic               sample_s;
    logic               rotate_s;

`ifdef RR_SAMPLE_ARB_LOCK_EN
    assign lock_s = lock;
`else
    assign lock_s = {N_REQ{1'b0}};
`endif

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i   (req),
        .owner_i (owner_q),
        .grant_o (pick_grant_s),
        .idx_o   (pick_idx_s),
        .any_o   (pick_any_s)
    );

    // A beat is sampled only while the owner both holds the grant and still requests.
    always_comb begin
        sample_s = 1'b0;
        if (state_q == ST_BUSY) begin
            sample_s = grant_q[owner_q] & req[owner_q];
        end else begin
            sample_s = 1'b0;
        end
    end

    // Next-state logic: grant issue, beat counting, rotation/release and capture.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        valid_d  = 1'b0;
        rotate_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    grant_d = pick_grant_s;
                    owner_d = pick_idx_s;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_BUSY;
                end else begin
                    grant_d = {N_REQ{1'b0}};
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (sample_s) begin
                    cap_d   = datain[owner_q];
                    valid_d = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        if (lock_s[owner_q]) begin
                            cnt_d = {CNT_W{1'b0}};
                        end else begin
                            rotate_s = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Owner dropped its request: release without sampling.
                    rotate_s = 1'b1;
                end

                if (rotate_s) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (pick_any_s) begin
                        grant_d = pick_grant_s;
                        owner_d = pick_idx_s;
                        state_d = ST_BUSY;
                    end else begin
                        grant_d = {N_REQ{1'b0}};
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = {N_REQ{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, grant, counter, capture flop and valid strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= {N_REQ{1'b0}};
            owner_q <= OWN_RST;
            cnt_q   <= {CNT_W{1'b0}};
            cap_q   <= CAP_RST;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            valid_q <= valid_d;
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign valid   = valid_q;
    assign dataout = ~cap_q;

endmodule
